// File: rtl/rx_signal_parser_pkg.sv
// rtl/rx_signal_parser_pkg.sv - rx_pkg: parser states, SIGNAL field layout and sizing constants
package rx_pkg;

    typedef enum logic [2:0] {
        ST_SIGNAL  = 3'd0,
        ST_SERVICE = 3'd1,
        ST_DATA    = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } rx_state_t;

    localparam int SIGNAL_BITS  = 24;
    localparam int SERVICE_BITS = 16;
    localparam int LEN_W        = 12;
    localparam int CNT_W        = 15;

    // Bit positions inside the SIGNAL field, position 0 = first received bit
    localparam int RATE_LSB = 0;
    localparam int RATE_MSB = 3;
    localparam int RES_POS  = 4;
    localparam int LEN_LSB  = 5;
    localparam int LEN_MSB  = 16;
    localparam int PAR_POS  = 17;
    localparam int TAIL_LSB = 18;
    localparam int TAIL_MSB = 23;

endpackage

// File: rtl/rx_signal_parser_if.sv
// rtl/rx_signal_parser_if.sv - bit stream in, decoded header and PSDU bytes out
interface rx_signal_parser_if;
    logic        Clear;
    logic        data_in;
    logic        data_in_valid;
    logic [3:0]  rate_out;
    logic [11:0] length_out;
    logic        hdr_valid;
    logic        hdr_error;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_last;
    logic        frame_done;

    modport master (
        output Clear, data_in, data_in_valid,
        input  rate_out, length_out, hdr_valid, hdr_error,
        input  byte_out, byte_valid, byte_last, frame_done
    );

    modport slave (
        input  Clear, data_in, data_in_valid,
        output rate_out, length_out, hdr_valid, hdr_error,
        output byte_out, byte_valid, byte_last, frame_done
    );
endinterface

// File: rtl/rx_signal_parser_bit_packer.sv
// rtl/rx_signal_parser_bit_packer.sv - rx_bit_packer: LSB-first 8-bit packer with registered byte output
module rx_bit_packer (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       i_clear,
    input  logic       i_shift_en,
    input  logic       i_bit,
    output logic [7:0] o_byte,
    output logic       o_byte_valid
);
    logic [7:0] r_shift;
    logic [2:0] r_cnt;
    logic [7:0] r_byte;
    logic       r_valid;
    logic [7:0] w_next;

    assign w_next = {i_bit, r_shift[7:1]};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_shift <= 8'd0;
            r_cnt   <= 3'd0;
            r_byte  <= 8'd0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_clear) begin
                r_shift <= 8'd0;
                r_cnt   <= 3'd0;
            end else if (i_shift_en) begin
                r_shift <= w_next;
                r_cnt   <= r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    r_byte  <= w_next;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_valid;
endmodule

// File: rtl/rx_signal_parser.sv
// rtl/rx_signal_parser.sv - SIGNAL header decode/validate and PSDU byte packing; RX_TAIL_CHECK_EN adds tail-zero check
module rx_signal_parser
    import rx_pkg::*;
#(
    parameter int MAX_LEN = 4095
) (
    input  logic Clk,
    input  logic Reset,
    rx_signal_parser_if.slave bus
);
    rx_state_t              r_state;
    rx_state_t              w_state_nxt;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [SIGNAL_BITS-1:0] r_sig_sr;
    logic [SIGNAL_BITS-1:0] w_sig_nxt;
    logic [3:0]             r_rate;
    logic [LEN_W-1:0]       r_length;
    logic                   r_hdr_valid;
    logic                   r_hdr_error;
    logic                   r_byte_last;
    logic                   r_frame_done;

    logic                   w_accept;
    logic [LEN_W-1:0]       w_len_field;
    logic                   w_tail_ok;
    logic                   w_hdr_ok;
    logic [CNT_W-1:0]       w_last_idx;
    logic                   w_sig_end;
    logic                   w_svc_end;
    logic                   w_data_shift;
    logic                   w_data_end;
    logic [7:0]             w_byte;
    logic                   w_byte_valid;

    // Clear wins over data: a bit presented together with Clear is dropped
    assign w_accept    = bus.data_in_valid & ~bus.Clear;
    assign w_sig_nxt   = {bus.data_in, r_sig_sr[SIGNAL_BITS-1:1]};
    assign w_len_field = w_sig_nxt[LEN_MSB:LEN_LSB];
    assign w_last_idx  = {r_length, 3'b000} - 15'd1;

`ifdef RX_TAIL_CHECK_EN
    assign w_tail_ok = (w_sig_nxt[TAIL_MSB:TAIL_LSB] == 6'd0);
`else
    assign w_tail_ok = 1'b1;
`endif

    assign w_hdr_ok = w_sig_nxt[RATE_MSB]
                    & ~w_sig_nxt[RES_POS]
                    & ~(^w_sig_nxt[PAR_POS:0])
                    & (w_len_field != '0)
                    & (int'({20'd0, w_len_field}) <= MAX_LEN)
                    & w_tail_ok;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)         r_state <= ST_SIGNAL;
        else if (bus.Clear) r_state <= ST_SIGNAL;
        else                r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sig_end    = 1'b0;
        w_svc_end    = 1'b0;
        w_data_shift = 1'b0;
        w_data_end   = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_SIGNAL: begin
                    if (r_bit_cnt == CNT_W'(SIGNAL_BITS - 1)) begin
                        w_sig_end   = 1'b1;
                        w_state_nxt = w_hdr_ok ? ST_SERVICE : ST_ERROR;
                    end
                end
                ST_SERVICE: begin
                    if (r_bit_cnt == CNT_W'(SERVICE_BITS - 1)) begin
                        w_svc_end   = 1'b1;
                        w_state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    w_data_shift = 1'b1;
                    if (r_bit_cnt == w_last_idx) begin
                        w_data_end  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_bit_cnt    <= '0;
            r_sig_sr     <= '0;
            r_rate       <= 4'd0;
            r_length     <= '0;
            r_hdr_valid  <= 1'b0;
            r_hdr_error  <= 1'b0;
            r_byte_last  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_hdr_valid  <= 1'b0;
            r_byte_last  <= 1'b0;
            r_frame_done <= 1'b0;
            if (bus.Clear) begin
                r_bit_cnt   <= '0;
                r_sig_sr    <= '0;
                r_hdr_error <= 1'b0;
            end else if (w_accept) begin
                if (r_state == ST_SIGNAL)
                    r_sig_sr <= w_sig_nxt;
                if (w_sig_end || w_svc_end || w_data_end)
                    r_bit_cnt <= '0;
                else if (r_state == ST_SIGNAL || r_state == ST_SERVICE || r_state == ST_DATA)
                    r_bit_cnt <= r_bit_cnt + 15'd1;
                // Fields are latched even for a rejected header so the MAC can log them
                if (w_sig_end) begin
                    r_rate       <= w_sig_nxt[RATE_MSB:RATE_LSB];
                    r_length     <= w_len_field;
                    r_hdr_valid  <= w_hdr_ok;
                    r_hdr_error  <= ~w_hdr_ok;
                    r_frame_done <= ~w_hdr_ok;
                end
                if (w_data_end) begin
                    r_byte_last  <= 1'b1;
                    r_frame_done <= 1'b1;
                end
            end
        end
    end

    rx_bit_packer u_packer (
        .Clk          (Clk),
        .Reset        (Reset),
        .i_clear      (bus.Clear),
        .i_shift_en   (w_data_shift),
        .i_bit        (bus.data_in),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid)
    );

    assign bus.rate_out   = r_rate;
    assign bus.length_out = r_length;
    assign bus.hdr_valid  = r_hdr_valid;
    assign bus.hdr_error  = r_hdr_error;
    assign bus.byte_out   = w_byte;
    assign bus.byte_valid = w_byte_valid;
    assign bus.byte_last  = r_byte_last;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_rx_signal_parser.sv
// tb/tb_rx_signal_parser.sv - directed bench for rx_signal_parser (default MAX_LEN and MAX_LEN=2 instances)
module tb_rx_signal_parser;
    logic Clk;
    logic Reset;

    rx_signal_parser_if bus_a ();
    rx_signal_parser_if bus_b ();

    rx_signal_parser u_dut_a (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_a)
    );

    rx_signal_parser #(.MAX_LEN(2)) u_dut_b (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] got[$];
    int         n_hdr  = 0;
    int         n_done = 0;
    int         n_last = 0;
    logic [7:0] last_byte = 8'd0;

    always @(negedge Clk) begin
        if (bus_a.byte_valid) got.push_back(bus_a.byte_out);
        if (bus_a.hdr_valid)  n_hdr++;
        if (bus_a.frame_done) n_done++;
        if (bus_a.byte_last) begin
            n_last++;
            last_byte = bus_a.byte_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    bit frm[$];

    // Frame: rate(R1..R4), reserved, LENGTH, explicit parity, tail, 16 zero service bits, payload LSB-first
    task automatic build(input logic [3:0] rate, input logic res, input logic [11:0] len,
                         input logic par, input logic [5:0] tail, input int nb,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] pl [3];
        frm.delete();
        pl[0] = b0; pl[1] = b1; pl[2] = b2;
        for (int i = 0; i < 4; i++)  frm.push_back(rate[i]);
        frm.push_back(res);
        for (int i = 0; i < 12; i++) frm.push_back(len[i]);
        frm.push_back(par);
        for (int i = 0; i < 6; i++)  frm.push_back(tail[i]);
        for (int i = 0; i < 16; i++) frm.push_back(1'b0);
        for (int j = 0; j < nb; j++)
            for (int i = 0; i < 8; i++) frm.push_back(pl[j][i]);
    endtask

    task automatic send_bit(input logic b, input logic v);
        bus_a.data_in = b; bus_a.data_in_valid = v;
        bus_b.data_in = b; bus_b.data_in_valid = v;
        @(posedge Clk);
        #1;
        bus_a.data_in_valid = 1'b0;
        bus_b.data_in_valid = 1'b0;
    endtask

    task automatic send_frm(input int n, input bit gaps, input bit lat);
        for (int i = 0; i < n; i++) begin
            send_bit(frm[i], 1'b1);
            if (lat && i >= 40)
                chk($sformatf("lat_bit%0d", i - 40), {31'd0, bus_a.byte_valid},
                    {31'd0, ((i - 40) % 8) == 7});
            if (gaps) send_bit(1'b1, 1'b0);
        end
    endtask

    task automatic do_clear();
        bus_a.Clear = 1'b1; bus_b.Clear = 1'b1;
        send_bit(1'b1, 1'b1);
        bus_a.Clear = 1'b0; bus_b.Clear = 1'b0;
    endtask

    int g0, d0, h0, l0;

    task automatic snap();
        g0 = got.size(); d0 = n_done; h0 = n_hdr; l0 = n_last;
    endtask

    initial begin
        Reset = 1'b0;
        bus_a.Clear = 1'b0; bus_a.data_in = 1'b0; bus_a.data_in_valid = 1'b0;
        bus_b.Clear = 1'b0; bus_b.data_in = 1'b0; bus_b.data_in_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_rate",   {28'd0, bus_a.rate_out}, 32'd0);
        chk("rst_len",    {20'd0, bus_a.length_out}, 32'd0);
        chk("rst_byte",   {24'd0, bus_a.byte_out}, 32'd0);
        chk("rst_pulses", {28'd0, bus_a.hdr_valid, bus_a.byte_valid, bus_a.byte_last, bus_a.frame_done}, 32'd0);
        chk("rst_err",    {31'd0, bus_a.hdr_error}, 32'd0);
        Reset = 1'b1;
        @(posedge Clk); #1;

        // T1: nominal LENGTH=3 frame
        snap();
        build(4'b1011, 1'b0, 12'd3, 1'b1, 6'd0, 3, 8'hA5, 8'h3C, 8'hFF);
        send_frm(frm.size(), 1'b0, 1'b0);
        repeat (3) send_bit(1'b0, 1'b0);
        chk("t1_rate",  {28'd0, bus_a.rate_out}, 32'hB);
        chk("t1_len",   {20'd0, bus_a.length_out}, 32'd3);
        chk("t1_nhdr",  n_hdr - h0, 1);
        chk("t1_nbyte", got.size() - g0, 3);
        chk("t1_b0",    {24'd0, got[g0]},     32'hA5);
        chk("t1_b1",    {24'd0, got[g0 + 1]}, 32'h3C);
        chk("t1_b2",    {24'd0, got[g0 + 2]}, 32'hFF);
        chk("t1_nlast", n_last - l0, 1);
        chk("t1_lastb", {24'd0, last_byte}, 32'hFF);
        chk("t1_ndone", n_done - d0, 1);
        chk("t1_err",   {31'd0, bus_a.hdr_error}, 32'd0);
        chk("t1_b_err_maxlen2", {31'd0, bus_b.hdr_error}, 32'd1);
        for (int i = 0; i < 16; i++) send_bit(1'b1, 1'b1);
        chk("t1_done_hold", got.size() - g0, 3);
        do_clear();

        // T2: parity flipped
        snap();
        build(4'b1011, 1'b0, 12'd3, 1'b0, 6'd0, 3, 8'hA5, 8'h3C, 8'hFF);
        send_frm(frm.size(), 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) send_bit(i[0], 1'b1);
        chk("t2_err",   {31'd0, bus_a.hdr_error}, 32'd1);
        chk("t2_ndone", n_done - d0, 1);
        chk("t2_nbyte", got.size() - g0, 0);
        chk("t2_nhdr",  n_hdr - h0, 0);
        do_clear();
        chk("t2_clr_err", {31'd0, bus_a.hdr_error}, 32'd0);

        // T3: valid toggling, byte_valid one cycle after each 8th bit
        snap();
        build(4'b1011, 1'b0, 12'd3, 1'b1, 6'd0, 3, 8'hA5, 8'h3C, 8'hFF);
        send_frm(frm.size(), 1'b1, 1'b1);
        chk("t3_nbyte", got.size() - g0, 3);
        chk("t3_b0",    {24'd0, got[g0]},     32'hA5);
        chk("t3_b1",    {24'd0, got[g0 + 1]}, 32'h3C);
        chk("t3_b2",    {24'd0, got[g0 + 2]}, 32'hFF);
        chk("t3_nlast", n_last - l0, 1);
        do_clear();

        // T4: LENGTH=0
        snap();
        build(4'b1011, 1'b0, 12'd0, 1'b1, 6'd0, 0, 8'h00, 8'h00, 8'h00);
        send_frm(frm.size(), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        chk("t4_err",   {31'd0, bus_a.hdr_error}, 32'd1);
        chk("t4_nhdr",  n_hdr - h0, 0);
        chk("t4_ndone", n_done - d0, 1);
        chk("t4_nbyte", got.size() - g0, 0);
        do_clear();

        // T5: Clear after 12 data bits, then LENGTH=1 frame 0x5A
        snap();
        build(4'b1011, 1'b0, 12'd3, 1'b1, 6'd0, 3, 8'hA5, 8'h3C, 8'hFF);
        send_frm(40 + 12, 1'b0, 1'b0);
        do_clear();
        g0 = got.size();
        build(4'b1011, 1'b0, 12'd1, 1'b0, 6'd0, 1, 8'h5A, 8'h00, 8'h00);
        send_frm(frm.size(), 1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("t5_nbyte", got.size() - g0, 1);
        chk("t5_byte",  {24'd0, got[g0]}, 32'h5A);
        chk("t5_nlast", n_last - l0, 1);
        chk("t5_lastb", {24'd0, last_byte}, 32'h5A);
        chk("t5_ndone", n_done - d0, 1);
        chk("t5_len",   {20'd0, bus_a.length_out}, 32'd1);
        chk("t5_b_byte", {24'd0, bus_b.byte_out}, 32'h5A);
        chk("t5_b_err",  {31'd0, bus_b.hdr_error}, 32'd0);
        do_clear();

        // T6: asynchronous reset mid-DATA
        build(4'b1011, 1'b0, 12'd3, 1'b1, 6'd0, 3, 8'hA5, 8'h3C, 8'hFF);
        send_frm(40 + 10, 1'b0, 1'b0);
        chk("t6_pre_byte", {24'd0, bus_a.byte_out}, 32'hA5);
        #2;
        Reset = 1'b0;
        #1;
        chk("t6_rate",   {28'd0, bus_a.rate_out}, 32'd0);
        chk("t6_len",    {20'd0, bus_a.length_out}, 32'd0);
        chk("t6_byte",   {24'd0, bus_a.byte_out}, 32'd0);
        chk("t6_flags",  {27'd0, bus_a.hdr_valid, bus_a.hdr_error, bus_a.byte_valid, bus_a.byte_last, bus_a.frame_done}, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;

        // T6b: tail bit 20 set
        snap();
        build(4'b1011, 1'b0, 12'd1, 1'b0, 6'b000100, 1, 8'h5A, 8'h00, 8'h00);
        send_frm(frm.size(), 1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
`ifdef RX_TAIL_CHECK_EN
        chk("t6_tail_err",   {31'd0, bus_a.hdr_error}, 32'd1);
        chk("t6_tail_nbyte", got.size() - g0, 0);
        chk("t6_tail_ndone", n_done - d0, 1);
`else
        chk("t6_tail_err",   {31'd0, bus_a.hdr_error}, 32'd0);
        chk("t6_tail_nbyte", got.size() - g0, 1);
        chk("t6_tail_byte",  {24'd0, bus_a.byte_out}, 32'h5A);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rx_signal_parser.md
Name: rx_signal_parser

Overview:
- Receiver stage directly downstream of the descrambler.
- Consumes the serial bit stream: 24-bit SIGNAL field, then 16 service bits, then LENGTH*8 descrambled PSDU bits.
- Decodes and validates the SIGNAL header (RATE, LENGTH, parity).
- Packs PSDU bits LSB-first into bytes for the MAC-side byte sink, and reports frame completion or header error.

Parameters:
MAX_LEN, 4095, largest accepted LENGTH in bytes; a larger header LENGTH is a header error (range 1..4095)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous active-low reset
Clear  input  1  synchronous frame restart, active-high; returns parser to SIGNAL state
data_in  input  1  serial bit from descrambler
data_in_valid  input  1  data_in qualifier; one bit accepted per cycle while high
rate_out  output  4  RATE field, rate_out[0] = first received bit (R1)
length_out  output  12  LENGTH field in bytes, LSB received first
hdr_valid  output  1  one-cycle pulse: header accepted
hdr_error  output  1  level: header rejected; held until Clear or Reset
byte_out  output  8  packed PSDU byte, bit0 = earliest bit
byte_valid  output  1  one-cycle pulse qualifying byte_out
byte_last  output  1  high together with byte_valid on the final PSDU byte
frame_done  output  1  one-cycle pulse at end of frame (last byte or header error)

Behaviour:
- Interface decided: one clock Clk; Reset is asynchronous, active-low; Reset takes priority over Clear, Clear over data.
- Reset (Reset low) values:
  - All outputs 0.
  - State SIGNAL; bit counter 0; shift registers 0.
- Bit acceptance: a bit is consumed only in cycles with data_in_valid=1. Gaps stall every counter.
- States:
  - SIGNAL: shift 24 bits. Bits 0-3 form RATE, bit 4 is reserved, bits 5-16 form LENGTH, bit 17 is parity, bits 18-23 are tail.
  - SERVICE: discard 16 bits.
  - DATA: pack LENGTH*8 bits.
  - DONE: ignore all bits.
  - ERROR: ignore all bits.
- SIGNAL exit, evaluated on the 24th accepted bit:
  - Header valid iff all of the following hold:
    - rate_out[3]=1;
    - reserved bit = 0;
    - even parity over bits 0-17;
    - 1 <= LENGTH <= MAX_LEN.
  - Valid header: on the next edge, latch rate_out and length_out, pulse hdr_valid, go to SERVICE.
  - Invalid header: on the next edge, latch the fields anyway, set hdr_error, pulse frame_done, go to ERROR. hdr_valid is never asserted.
- SERVICE to DATA after the 16th accepted service bit. Service bit values are ignored.
- DATA:
  - Bit counter 15 bits wide; compare against {LENGTH,3'b0}-1 with no overflow (max 32759).
  - Every 8th accepted bit: byte_out is registered and byte_valid pulses on the next edge. Latency is 1 cycle after the 8th bit's valid cycle.
  - The final bit additionally sets byte_last and pulses frame_done in the same cycle as byte_valid; the state then goes to DONE.
- DONE and ERROR: hold until Clear or Reset. Trailing bits from the descrambler's waiting state are dropped.
- Clear mid-frame:
  - Partial byte discarded; no byte_valid or frame_done emitted.
  - hdr_error cleared; rate_out and length_out keep their last values.
  - Parsing restarts at SIGNAL bit 0 on the next accepted bit.
  - A bit presented with Clear=1 is dropped.
- byte_out holds its value between pulses. byte_valid, hdr_valid, byte_last and frame_done are never high for more than one cycle.

Optional Feature:
- Macro RX_TAIL_CHECK_EN.
- Defined: tail bits 18-23 must all be 0 for a valid header; any 1 yields hdr_error and the ERROR path.
- Undefined: tail bits are ignored.

Decomposition:
- Package rx_pkg holds:
  - state encoding (SIGNAL, SERVICE, DATA, DONE, ERROR);
  - SIGNAL field bit positions;
  - constants SIGNAL_BITS=24, SERVICE_BITS=16;
  - LENGTH width 12.
- One natural sub-module, rx_bit_packer: 8-bit LSB-first shift packer with bit-count wrap and output register, driven by a shift enable and a flush/clear.

Test Plan:
1. R1..R4=1,1,0,1, R=0, LENGTH=3, parity=1, tail 0, 16 zeros, then bytes 0xA5,0x3C,0xFF LSB-first, valid every cycle -> rate_out=4'b1011, length_out=3, one hdr_valid, byte_valid x3 with 0xA5/0x3C/0xFF, byte_last and frame_done with 0xFF, then DONE.
2. Same frame with parity bit flipped to 0 -> hdr_error=1, frame_done pulse, zero byte_valid even with 100 further bits.
3. Same frame with data_in_valid toggling 1/0 -> identical byte sequence, each byte_valid exactly 1 cycle after its 8th valid bit.
4. Header LENGTH=0, and separately LENGTH>MAX_LEN with MAX_LEN=2 and LENGTH=3 -> hdr_error.
5. Clear asserted after 12 data bits, then a fresh LENGTH=1 frame carrying 0x5A -> no byte from the aborted frame; one byte 0x5A with byte_last.
6. Reset pulled low asynchronously mid-DATA -> all outputs 0 immediately. With RX_TAIL_CHECK_EN, tail bit 20=1 -> hdr_error; without the macro the same frame parses normally.
